// File: rtl/alu_arbiter_if.sv
// Request/ALU/response bundle between requesters, the shared ALU and alu_arbiter.
// The arbiter uses the slave modport; the environment (requesters, ALU, consumer) uses master.
interface alu_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 20
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_input1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_input2;
    logic [NUM_REQ*2-1:0]          req_select;
    logic [DATA_WIDTH-1:0]         alu_input1;
    logic [DATA_WIDTH-1:0]         alu_input2;
    logic [1:0]                    alu_select;
    logic [DATA_WIDTH-1:0]         alu_result;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic [ID_WIDTH-1:0]           resp_id;

    modport master (
        output req_valid, req_input1, req_input2, req_select, alu_result, resp_ready,
        input  req_ready, alu_input1, alu_input2, alu_select, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_input1, req_input2, req_select, alu_result, resp_ready,
        output req_ready, alu_input1, alu_input2, alu_select, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 20-bit ALU between NUM_REQ requesters with a held response register.
// Optional per-requester saturating grant counters under macro ALU_ARB_STATS_EN.
//
// state  | meaning
// S_IDLE | searching for a valid requester from rr_ptr, grant is combinational
// S_EXEC | captured operands drive the ALU, result latched at the clock edge
// S_RESP | response held until the consumer accepts it
module alu_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_arbiter_if.slave             bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_count
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [1:0]            sel_q, sel_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
    logic                  resp_valid_q, resp_valid_d;

    logic [ID_WIDTH-1:0]   cand [NUM_REQ];
    logic [ID_WIDTH-1:0]   winner;
    logic                  grant;
    logic [NUM_REQ-1:0]    ready;

    // cand[k] is the k-th requester index visited when searching upward from rr_ptr
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cand[k] = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
        end
    end

    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant && bus.req_valid[cand[k]]) begin
                grant  = 1'b1;
                winner = cand[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        sel_d        = sel_q;
        id_d         = id_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        ready        = '0;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    ready[winner] = 1'b1;
                    op_a_d        = bus.req_input1[DATA_WIDTH*winner +: DATA_WIDTH];
                    op_b_d        = bus.req_input2[DATA_WIDTH*winner +: DATA_WIDTH];
                    sel_d         = bus.req_select[2*winner +: 2];
                    id_d          = winner;
                    rr_ptr_d      = ID_WIDTH'((int'(winner) + 1) % NUM_REQ);
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_data_d  = bus.alu_result;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sel_q        <= '0;
            id_q         <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // the grant is combinational, so it must be masked while reset is held
    assign bus.req_ready  = rst ? '0 : ready;
    assign bus.alu_input1 = op_a_q;
    assign bus.alu_input2 = op_b_q;
    assign bus.alu_select = sel_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (state_q == S_IDLE && grant && cnt_q[winner] != 16'hFFFF) begin
            cnt_q[winner] <= cnt_q[winner] + 16'd1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_count[16*i +: 16] = cnt_q[i];
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: grant checker pushes expected responses, a monitor pops them.
module tb_alu_arbiter;
    localparam int NR = 4;
    localparam int DW = 20;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [NR*16-1:0] grant_count;
`endif

    alu_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [1:0] s);
        logic [DW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (s)
            2'b00:   return sum[DW-1:0];
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // the shared ALU itself, purely combinational
    assign bus.alu_result = alu_ref(bus.alu_input1, bus.alu_input2, bus.alu_select);

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [NR-1:0] vld_r;
    logic [DW-1:0] a_r [NR];
    logic [DW-1:0] b_r [NR];
    logic [1:0]    s_r [NR];
    logic [NR-1:0] gnt_last = '0;
    int            m_ptr    = 0;
    bit            busy     = 1'b0;
    bit            auto_drive;
    int            pct;
    int            rr_mode;

    task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // grant checker: round-robin reference, one outstanding operation at a time
    always @(negedge clk) begin : grant_chk
        logic [NR-1:0] exp_r;
        int            w;
        int            idx;
        if (rst) begin
            chk(bus.req_ready == '0, "rst_req_ready", bus.req_ready, 0);
            chk(bus.resp_valid == 1'b0, "rst_resp_valid", bus.resp_valid, 0);
            chk(bus.resp_data == '0, "rst_resp_data", bus.resp_data, 0);
            chk(bus.resp_id == '0, "rst_resp_id", bus.resp_id, 0);
            chk(bus.alu_input1 == '0 && bus.alu_input2 == '0 && bus.alu_select == '0,
                "rst_alu_regs", {bus.alu_input1, bus.alu_input2}, 0);
            m_ptr    = 0;
            busy     = 1'b0;
            gnt_last = '0;
            exp_q.delete();
        end else begin
            exp_r = '0;
            w     = -1;
            if (!busy) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (w < 0 && vld_r[idx]) w = idx;
                end
            end
            if (w >= 0) exp_r[w] = 1'b1;
            chk(bus.req_ready == exp_r, "req_ready", bus.req_ready, exp_r);
            gnt_last = bus.req_ready & bus.req_valid;
            if (w >= 0) begin
                exp_q.push_back('{id: IW'(w), data: alu_ref(a_r[w], b_r[w], s_r[w]), cyc: cyc});
                m_ptr = (w + 1) % NR;
                busy  = 1'b1;
            end else if (busy && bus.resp_valid && bus.resp_ready) begin
                busy = 1'b0;
            end
        end
    end

    // response monitor
    always @(negedge clk) begin : resp_mon
        static bit seen = 1'b0;
        exp_t      e;
        #2;
        if (rst) begin
            seen = 1'b0;
        end else if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (!seen && (bus.resp_valid || cyc == e.cyc + 2)) begin
                chk(bus.resp_valid && cyc == e.cyc + 2, "resp_latency", cyc, e.cyc + 2);
                if (bus.resp_valid) seen = 1'b1;
            end
            if (seen) begin
                chk(bus.resp_data == e.data, "resp_data", bus.resp_data, e.data);
                chk(bus.resp_id == e.id, "resp_id", bus.resp_id, e.id);
                if (bus.resp_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end else begin
            chk(!bus.resp_valid, "spurious_resp", bus.resp_valid, 0);
        end
    end

    task automatic apply();
        bus.req_valid = vld_r;
        for (int i = 0; i < NR; i++) begin
            bus.req_input1[DW*i +: DW] = a_r[i];
            bus.req_input2[DW*i +: DW] = b_r[i];
            bus.req_select[2*i +: 2]   = s_r[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_drive) begin
            for (int i = 0; i < NR; i++) begin
                if (gnt_last[i] || !vld_r[i]) begin
                    vld_r[i] = ($urandom_range(0, 99) < pct);
                    a_r[i]   = DW'($urandom);
                    b_r[i]   = DW'($urandom);
                    s_r[i]   = 2'($urandom_range(0, 3));
                end
            end
        end
        case (rr_mode)
            0:       bus.resp_ready = 1'b1;
            1:       bus.resp_ready = 1'($urandom_range(0, 1));
            default: bus.resp_ready = 1'b0;
        endcase
        apply();
    endtask

    task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] s);
        bit got;
        got = 1'b0;
        vld_r[i] = 1'b1;
        a_r[i]   = a;
        b_r[i]   = b;
        s_r[i]   = s;
        apply();
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (gnt_last[i]) got = 1'b1;
        end
        vld_r[i] = 1'b0;
        apply();
        chk(got, "grant_timeout", got, 1);
        repeat (4) step();
    endtask

    initial begin
        bit got;
        rst            = 1'b1;
        auto_drive     = 1'b0;
        pct            = 0;
        rr_mode        = 0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            a_r[i] = DW'($urandom);
            b_r[i] = DW'($urandom);
            s_r[i] = 2'($urandom_range(0, 3));
        end
        vld_r = '1;
        apply();
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        vld_r = '0;
        apply();
        step();

        issue(0, 20'h00003, 20'h00005, 2'b00);
        issue(0, 20'hFFFFF, 20'h00002, 2'b00);
        issue(1, 20'hF0F0F, 20'h0FF00, 2'b01);
        issue(2, 20'hF0F0F, 20'h0FF00, 2'b10);
        issue(3, 20'hF0F0F, 20'h0FF00, 2'b11);

        // all requesters valid, consumer always ready
        auto_drive = 1'b1;
        pct        = 100;
        repeat (20) step();

        // backpressure held for 10 cycles once a response is up
        rr_mode = 2;
        for (int n = 0; n < 10 && !bus.resp_valid; n++) step();
        repeat (10) step();
        rr_mode = 0;
        repeat (6) step();

        // reset while an operation is in EXEC
        got = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            step();
            if (gnt_last != '0) got = 1'b1;
        end
        chk(got, "exec_grant_timeout", got, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (12) step();

        // random traffic with random backpressure
        pct     = 40;
        rr_mode = 1;
        repeat (400) step();

        pct     = 0;
        rr_mode = 0;
        repeat (10) step();
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
